rr_mux8_arbiter: RTL and testbench

//   Round-robin arbiter/sequencer sharing one 1-bit output channel among 8

---
 rtl/rr_mux8_arbiter_if.sv | 12 +
 rtl/rr_mux8_arbiter.sv | 78 +++++++
 tb/tb_rr_mux8_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/rr_mux8_arbiter_if.sv
// rr_mux8_arbiter_if: request/data/grant bundle between 8 serial sources and the arbiter
interface rr_mux8_arbiter_if;
  logic [7:0] req;
  logic [7:0] data_in;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       data_out;
  logic       data_valid;
  logic       busy;
  modport master (output req, data_in, input gnt, sel, data_out, data_valid, busy);
  modport slave  (input req, data_in, output gnt, sel, data_out, data_valid, busy);
endinterface

// File: rtl/rr_mux8_arbiter.sv
// rr_mux8_arbiter: round-robin 8:1 serial channel sharing with bounded tenure
module rr_mux8_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input logic               clk,
  input logic               rst_n,
  rr_mux8_arbiter_if.slave  io_bus
);
  localparam int CW = $clog2(MAX_HOLD) + 1;
  typedef enum logic {IDLE, GRANT} state_t;
  state_t        r_state, w_state_n;
  logic [2:0]    r_sel, w_sel_n, r_ptr, w_ptr_n;
  logic [CW-1:0] r_hold, w_hold_n;
  logic          r_dout, r_dval;
  logic          w_release;
  logic [3:0]    w_m1;
  logic [1:0]    w_m2;
  logic          w_mux;
  function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] s);
    logic [2:0] p;
    p = s;
    for (int k = 7; k >= 0; k--)
      if (r[s + 3'(k)]) p = s + 3'(k);
    return p;
  endfunction
  // 8:1 select as a tree of 2:1 stages driven by the registered select
  always_comb begin
    for (int k = 0; k < 4; k++) w_m1[k] = r_sel[0] ? io_bus.data_in[2*k+1] : io_bus.data_in[2*k];
    for (int k = 0; k < 2; k++) w_m2[k] = r_sel[1] ? w_m1[2*k+1] : w_m1[2*k];
    w_mux = r_sel[2] ? w_m2[1] : w_m2[0];
  end
  // a tenure ends when the holder lets go or has used its hold budget
  assign w_release = !io_bus.req[r_sel] || (r_hold == CW'(MAX_HOLD - 1));
  // next-state: pick from ptr out of idle, hand over from sel+1 on release with no bubble
  always_comb begin
    w_state_n = r_state;
    w_sel_n   = r_sel;
    w_ptr_n   = r_ptr;
    w_hold_n  = r_hold;
    if (r_state == IDLE) begin
      if (|io_bus.req) begin
        w_state_n = GRANT;
        w_sel_n   = pick(io_bus.req, r_ptr);
        w_hold_n  = '0;
      end
    end else if (!w_release) begin
      w_hold_n = r_hold + CW'(1);
    end else begin
      w_ptr_n  = r_sel + 3'd1;
      w_hold_n = '0;
      if (|io_bus.req) w_sel_n = pick(io_bus.req, r_sel + 3'd1);
      else w_state_n = IDLE;
    end
  end
  // arbitration state and registered output bit; reset abandons any tenure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_hold  <= '0;
      r_dout  <= 1'b0;
      r_dval  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_sel   <= w_sel_n;
      r_ptr   <= w_ptr_n;
      r_hold  <= w_hold_n;
      r_dout  <= w_mux;
      r_dval  <= (r_state == GRANT) && io_bus.req[r_sel];
    end
  end
  assign io_bus.busy       = (r_state == GRANT);
  assign io_bus.gnt        = io_bus.busy ? (8'b1 << r_sel) : 8'h00;
  assign io_bus.sel        = r_sel;
  assign io_bus.data_out   = r_dout;
  assign io_bus.data_valid = r_dval;
endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// tb_rr_mux8_arbiter: directed vector table plus corner sequences and a random invariant sweep
module tb_rr_mux8_arbiter;
  localparam int MH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  rr_mux8_arbiter_if bus ();
  rr_mux8_arbiter #(.MAX_HOLD(MH)) dut (.clk(clk), .rst_n(rst_n), .io_bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] req;
    logic [7:0] din;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       dout;
    logic       dval;
    logic       busy;
  } vec_t;
  vec_t tv [24];
  task automatic step(input logic [7:0] r, input logic [7:0] d);
    bus.req = r;
    bus.data_in = d;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [7:0] g, input logic [2:0] s,
                     input logic d, input logic v, input logic b);
    n_chk++;
    if (bus.gnt !== g || bus.sel !== s || bus.data_out !== d || bus.data_valid !== v || bus.busy !== b) begin
      n_fail++;
      $display("FAIL %s: got gnt=%h sel=%0d dout=%b dval=%b busy=%b, expected gnt=%h sel=%0d dout=%b dval=%b busy=%b",
               nm, bus.gnt, bus.sel, bus.data_out, bus.data_valid, bus.busy, g, s, d, v, b);
    end
  endtask
  initial begin
    logic [7:0] nr, pg;
    int run, mx;
    int wt [8];
    tv[0]  = '{8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
    tv[1]  = '{8'h04, 8'h04, 8'h04, 3'd2, 1'b0, 1'b0, 1'b1};
    tv[2]  = '{8'h04, 8'h00, 8'h04, 3'd2, 1'b0, 1'b1, 1'b1};
    tv[3]  = '{8'h04, 8'h04, 8'h04, 3'd2, 1'b1, 1'b1, 1'b1};
    tv[4]  = '{8'h04, 8'h00, 8'h04, 3'd2, 1'b0, 1'b1, 1'b1};
    tv[5]  = '{8'h04, 8'h04, 8'h04, 3'd2, 1'b1, 1'b1, 1'b1};
    tv[6]  = '{8'h04, 8'h00, 8'h04, 3'd2, 1'b0, 1'b1, 1'b1};
    tv[7]  = '{8'h00, 8'h00, 8'h00, 3'd2, 1'b0, 1'b0, 1'b0};
    tv[8]  = '{8'h28, 8'h08, 8'h08, 3'd3, 1'b0, 1'b0, 1'b1};
    tv[9]  = '{8'h28, 8'h08, 8'h08, 3'd3, 1'b1, 1'b1, 1'b1};
    tv[10] = '{8'h28, 8'h00, 8'h08, 3'd3, 1'b0, 1'b1, 1'b1};
    tv[11] = '{8'h20, 8'h20, 8'h20, 3'd5, 1'b0, 1'b0, 1'b1};
    tv[12] = '{8'h20, 8'h20, 8'h20, 3'd5, 1'b1, 1'b1, 1'b1};
    tv[13] = '{8'h00, 8'h00, 8'h00, 3'd5, 1'b0, 1'b0, 1'b0};
    tv[14] = '{8'h80, 8'h80, 8'h80, 3'd7, 1'b0, 1'b0, 1'b1};
    tv[15] = '{8'h81, 8'h80, 8'h80, 3'd7, 1'b1, 1'b1, 1'b1};
    tv[16] = '{8'h81, 8'h00, 8'h80, 3'd7, 1'b0, 1'b1, 1'b1};
    tv[17] = '{8'h81, 8'h00, 8'h80, 3'd7, 1'b0, 1'b1, 1'b1};
    tv[18] = '{8'h81, 8'h01, 8'h01, 3'd0, 1'b0, 1'b1, 1'b1};
    tv[19] = '{8'h81, 8'h01, 8'h01, 3'd0, 1'b1, 1'b1, 1'b1};
    tv[20] = '{8'h81, 8'h00, 8'h01, 3'd0, 1'b0, 1'b1, 1'b1};
    tv[21] = '{8'h81, 8'h00, 8'h01, 3'd0, 1'b0, 1'b1, 1'b1};
    tv[22] = '{8'h81, 8'h00, 8'h80, 3'd7, 1'b0, 1'b1, 1'b1};
    tv[23] = '{8'h00, 8'h00, 8'h00, 3'd7, 1'b0, 1'b0, 1'b0};
    bus.req = 8'h00;
    bus.data_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step(tv[i].req, tv[i].din);
      chk($sformatf("vec%0d", i), tv[i].gnt, tv[i].sel, tv[i].dout, tv[i].dval, tv[i].busy);
    end
    for (int k = 0; k < 9 * MH; k++) begin
      step(8'hFF, 8'h00);
      chk($sformatf("rotate%0d", k), 8'h01 << ((k / MH) % 8), 3'((k / MH) % 8), 1'b0, k > 0, 1'b1);
    end
    step(8'h00, 8'h00);
    chk("rotate_idle", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    step(8'h40, 8'h40);
    chk("rst_pre0", 8'h40, 3'd6, 1'b0, 1'b0, 1'b1);
    step(8'h40, 8'h40);
    chk("rst_pre1", 8'h40, 3'd6, 1'b1, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.req = 8'hC0;
    rst_n = 1'b1;
    step(8'hC0, 8'h40);
    chk("rst_restart", 8'h40, 3'd6, 1'b0, 1'b0, 1'b1);
    step(8'h00, 8'h00);
    step(8'h00, 8'h00);
    chk("rnd_idle", 8'h00, 3'd6, 1'b0, 1'b0, 1'b0);
    pg = 8'h00;
    run = 0;
    for (int i = 0; i < 8; i++) wt[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 8; i++)
        nr[i] = bus.gnt[i] ? ($urandom_range(3) != 0) : (bus.req[i] | ($urandom_range(2) == 0));
      step(nr, 8'($urandom));
      n_chk++;
      if ($countones(bus.gnt) > 1) begin
        n_fail++;
        $display("FAIL onehot c=%0d: got gnt=%h, expected one-hot or zero", c, bus.gnt);
      end
      if (bus.gnt != 8'h00) begin
        n_chk++;
        if (bus.gnt !== (8'h01 << bus.sel)) begin
          n_fail++;
          $display("FAIL sel_enc c=%0d: got sel=%0d with gnt=%h", c, bus.sel, bus.gnt);
        end
      end
      run = (bus.gnt != 8'h00 && bus.gnt == pg) ? run + 1 : 1;
      if (run > MH) begin
        n_chk++;
        if ((nr & ~bus.gnt) != 8'h00) begin
          n_fail++;
          $display("FAIL tenure c=%0d: got gnt=%h kept %0d cycles with req=%h, expected at most %0d", c, bus.gnt, run, nr, MH);
        end
        run = 1;
      end
      pg = bus.gnt;
      mx = 0;
      for (int i = 0; i < 8; i++) begin
        wt[i] = (bus.req[i] && !bus.gnt[i]) ? wt[i] + 1 : 0;
        if (wt[i] > mx) mx = wt[i];
      end
      n_chk++;
      if (mx > 7 * MH) begin
        n_fail++;
        $display("FAIL starve c=%0d: got wait=%0d, expected at most %0d", c, mx, 7 * MH);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
